imem_port_arbiter: RTL and testbench

- Shares the single read port of the 128-word instruction memory between two requesters: CPU instruction fetch and the VGA debug viewer.
- Uses a one-cycle synchronous memory read.
- CPU fetch has priority. A starvation counter guarantees the debug reader a slot.
- Sits between the core's fetch stage or debug scanner and the memory array. Also screens out-of-range and misaligned CPU fetches.

---
 rtl/imem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the single-read-port instruction memory.
// CPU fetch has priority. A starvation counter force-grants a waiting debug reader.
module imem_port_arbiter #(
   parameter int unsigned ADDR_W       = 7,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req_valid,
   input  logic [31:0]       cpu_req_addr,
   output logic              cpu_req_ready,
   output logic              cpu_rsp_valid,
   output logic [31:0]       cpu_rsp_data,
   output logic              cpu_rsp_err,
   input  logic              dbg_req_valid,
   input  logic [ADDR_W-1:0] dbg_req_addr,
   output logic              dbg_req_ready,
   output logic              dbg_rsp_valid,
   output logic [31:0]       dbg_rsp_data,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned WORD_LO = 2;
   localparam int unsigned WORD_HI = ADDR_W + 1;
   localparam int unsigned TAG_LO  = ADDR_W + 2;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      P_NONE    = 2'd0,
      P_CPU     = 2'd1,
      P_CPU_OOR = 2'd2,
      P_DBG     = 2'd3
   } pend_e;

   pend_e             state;
   pend_e             state_nxt;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_cnt_nxt;
   logic              cpu_err_q;
   logic              cpu_err_nxt;
   logic [31:0]       cpu_data_q;
   logic [31:0]       dbg_data_q;

   logic              force_dbg;
   logic              grant_dbg;
   logic              grant_cpu;
   logic              cpu_oor;
   logic              cpu_mis;

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      force_dbg = (starve_cnt == LIMIT);
      cpu_oor   = |cpu_req_addr[31:TAG_LO];
      cpu_mis   = |cpu_req_addr[WORD_LO-1:0];
      grant_dbg = rst_n && dbg_req_valid && (force_dbg || !cpu_req_valid);
      grant_cpu = rst_n && cpu_req_valid && !grant_dbg;
   end

   // Handshake and memory drive follow the grant in the same cycle.
   always_comb begin
      cpu_req_ready = grant_cpu;
      dbg_req_ready = grant_dbg;
      mem_en        = grant_dbg || (grant_cpu && !cpu_oor);
      mem_addr      = '0;
      if (grant_dbg) begin
         mem_addr = dbg_req_addr;
      end else if (grant_cpu) begin
         mem_addr = cpu_req_addr[WORD_HI:WORD_LO];
      end
   end

   // Pending-response state, starvation counter and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= P_NONE;
         starve_cnt <= '0;
         cpu_err_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
         cpu_err_q  <= cpu_err_nxt;
      end
   end

   always_comb begin
      state_nxt      = P_NONE;
      cpu_err_nxt    = 1'b0;
      starve_cnt_nxt = starve_cnt;
      if (grant_dbg) begin
         state_nxt = P_DBG;
      end else if (grant_cpu) begin
         state_nxt   = cpu_oor ? P_CPU_OOR : P_CPU;
         cpu_err_nxt = cpu_oor | cpu_mis;
      end
      if (!dbg_req_valid || grant_dbg) begin
         starve_cnt_nxt = '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
   end

   // Response outputs; data shows the memory word in the response cycle, else the last value.
   always_comb begin
      cpu_rsp_valid = 1'b0;
      dbg_rsp_valid = 1'b0;
      cpu_rsp_data  = cpu_data_q;
      dbg_rsp_data  = dbg_data_q;
      cpu_rsp_err   = cpu_err_q;
      unique case (state)
         P_CPU: begin
            cpu_rsp_valid = 1'b1;
            cpu_rsp_data  = mem_rdata;
         end
         P_CPU_OOR: begin
            cpu_rsp_valid = 1'b1;
            cpu_rsp_data  = NOP_INSTR;
         end
         P_DBG: begin
            dbg_rsp_valid = 1'b1;
            dbg_rsp_data  = mem_rdata;
         end
         default: begin
            cpu_rsp_valid = 1'b0;
         end
      endcase
   end

   // Capture delivered data so it holds once the valid pulse ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_data_q <= '0;
         dbg_data_q <= '0;
      end else begin
         if (cpu_rsp_valid) begin
            cpu_data_q <= cpu_rsp_data;
         end
         if (dbg_rsp_valid) begin
            dbg_data_q <= dbg_rsp_data;
         end
      end
   end

   a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
      !(cpu_req_ready && dbg_req_ready));

   a_rsp_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(cpu_rsp_valid && dbg_rsp_valid));

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Table-driven bench for imem_port_arbiter with a response scoreboard and a bench-side memory.
module tb_imem_port_arbiter;

   localparam int unsigned ADDR_W = 7;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk;
   logic              rst_n;
   logic              cpu_req_valid;
   logic [31:0]       cpu_req_addr;
   logic              cpu_req_ready;
   logic              cpu_rsp_valid;
   logic [31:0]       cpu_rsp_data;
   logic              cpu_rsp_err;
   logic              dbg_req_valid;
   logic [ADDR_W-1:0] dbg_req_addr;
   logic              dbg_req_ready;
   logic              dbg_rsp_valid;
   logic [31:0]       dbg_rsp_data;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;

   logic [31:0] mem_model [0:127];

   typedef struct {
      logic              cv;
      logic [31:0]       ca;
      logic              dv;
      logic [ADDR_W-1:0] da;
      logic              ecr;
      logic              edr;
      logic              eme;
      logic [ADDR_W-1:0] ema;
   } vec_t;

   typedef struct {
      logic        is_dbg;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   rsp_t        sb[$];
   vec_t        tbl[14];
   vec_t        v;
   logic [31:0] last_cpu;
   logic [31:0] last_dbg;
   int          n_cmp;
   int          n_bad;

   imem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_err(cpu_rsp_err),
      .dbg_req_valid(dbg_req_valid), .dbg_req_addr(dbg_req_addr), .dbg_req_ready(dbg_req_ready),
      .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle synchronous-read memory.
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem_model[mem_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of requests, check grant-side outputs, then check the response edge.
   task automatic step(input vec_t s);
      rsp_t e;
      logic oor;
      logic mis;
      cpu_req_valid = s.cv;
      cpu_req_addr  = s.ca;
      dbg_req_valid = s.dv;
      dbg_req_addr  = s.da;
      #1;
      chk("cpu_req_ready", 32'(cpu_req_ready), 32'(s.ecr));
      chk("dbg_req_ready", 32'(dbg_req_ready), 32'(s.edr));
      chk("mem_en", 32'(mem_en), 32'(s.eme));
      if (s.eme) chk("mem_addr", 32'(mem_addr), 32'(s.ema));
      if (s.edr) begin
         e.is_dbg = 1'b1;
         e.data   = mem_model[s.da];
         e.err    = 1'b0;
         sb.push_back(e);
      end else if (s.ecr) begin
         oor      = |s.ca[31:9];
         mis      = |s.ca[1:0];
         e.is_dbg = 1'b0;
         e.data   = oor ? NOP : mem_model[s.ca[8:2]];
         e.err    = oor | mis;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(!e.is_dbg));
         chk("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(e.is_dbg));
         if (e.is_dbg) begin
            chk("dbg_rsp_data", dbg_rsp_data, e.data);
            last_dbg = e.data;
         end else begin
            chk("cpu_rsp_data", cpu_rsp_data, e.data);
            chk("cpu_rsp_err", 32'(cpu_rsp_err), 32'(e.err));
            last_cpu = e.data;
         end
      end else begin
         chk("cpu_rsp_valid_idle", 32'(cpu_rsp_valid), 32'd0);
         chk("dbg_rsp_valid_idle", 32'(dbg_rsp_valid), 32'd0);
         chk("cpu_rsp_data_hold", cpu_rsp_data, last_cpu);
         chk("dbg_rsp_data_hold", dbg_rsp_data, last_dbg);
      end
   endtask

   // Both requesters valid for n cycles; debug is expected to win on the listed cycles only.
   task automatic starve_run(input int n, input int w0, input int w1);
      vec_t s;
      for (int k = 0; k < n; k++) begin
         s.cv  = 1'b1;
         s.ca  = 32'h0000_0020;
         s.dv  = 1'b1;
         s.da  = 7'd9;
         s.edr = (k == w0) || (k == w1);
         s.ecr = !s.edr;
         s.eme = 1'b1;
         s.ema = s.edr ? 7'd9 : 7'd8;
         step(s);
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      last_cpu = '0;
      last_dbg = '0;
      for (int i = 0; i < 128; i++) begin
         mem_model[i] = {8'hC0, 8'(i), 8'(~i), 8'(i * 3)};
      end
      mem_model[4] = 32'hDEAD_BEEF;

      //            cv    ca            dv    da      ecr   edr   eme   ema
      tbl[0]  = '{1'b1, 32'h0000_0010, 1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 7'd4};
      tbl[1]  = '{1'b1, 32'h0000_0000, 1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 7'd0};
      tbl[2]  = '{1'b1, 32'h0000_0004, 1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 7'd1};
      tbl[3]  = '{1'b1, 32'h0000_0008, 1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 7'd2};
      tbl[4]  = '{1'b0, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 7'd0};
      tbl[5]  = '{1'b1, 32'h0000_0400, 1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 7'd0};
      tbl[6]  = '{1'b1, 32'h0000_0006, 1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 7'd1};
      tbl[7]  = '{1'b0, 32'h0000_0000, 1'b1, 7'd127, 1'b0, 1'b1, 1'b1, 7'd127};
      tbl[8]  = '{1'b0, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 7'd0};
      tbl[9]  = '{1'b1, 32'h0000_01FC, 1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 7'd127};
      tbl[10] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 7'd0};
      tbl[11] = '{1'b1, 32'h0000_000C, 1'b1, 7'd5,   1'b1, 1'b0, 1'b1, 7'd3};
      tbl[12] = '{1'b0, 32'h0000_0000, 1'b1, 7'd5,   1'b0, 1'b1, 1'b1, 7'd5};
      tbl[13] = '{1'b0, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 7'd0};

      rst_n         = 1'b0;
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      dbg_req_valid = 1'b0;
      dbg_req_addr  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst cpu_req_ready", 32'(cpu_req_ready), 32'd0);
      chk("rst dbg_req_ready", 32'(dbg_req_ready), 32'd0);
      chk("rst cpu_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      chk("rst dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
      chk("rst mem_en", 32'(mem_en), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst cpu_rsp_err", 32'(cpu_rsp_err), 32'd0);
      chk("rst cpu_rsp_data", cpu_rsp_data, 32'd0);
      chk("rst dbg_rsp_data", dbg_rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         v = tbl[i];
         step(v);
      end

      // Continuous contention: debug forced on cycle 8, and again 9 cycles later.
      starve_run(18, 8, 17);

      // Build up starvation, then reset with a CPU response in flight.
      starve_run(4, -1, -1);
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h0000_0010;
      dbg_req_valid = 1'b1;
      dbg_req_addr  = 7'd9;
      #1;
      chk("pre-reset cpu_req_ready", 32'(cpu_req_ready), 32'd1);
      rst_n         = 1'b0;
      cpu_req_valid = 1'b0;
      dbg_req_valid = 1'b0;
      #1;
      chk("in-reset cpu_req_ready", 32'(cpu_req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("in-reset cpu_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset cpu_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      chk("post-reset dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
      sb.delete();
      last_cpu = '0;
      last_dbg = '0;

      // Counter restarted at 0: debug must wait the full 8 cycles again.
      starve_run(9, 8, -1);
      v = tbl[13];
      step(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
